// File: rtl/jtoutrun_subbridge.sv
// jtoutrun_subbridge: main-CPU bridge onto the shared Out Run sub-CPU bus.
// Optional wait timeout enabled by defining JTOUTRUN_BRIDGE_TIMEOUT_EN.
module jtoutrun_subbridge #(
    parameter int SETTLE  = 2,
    parameter int HOLD    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        main_cs,
    input  logic [18:0] main_A,
    input  logic [1:0]  main_dsn,
    input  logic        main_rnw,
    input  logic [15:0] main_dout,
    output logic [15:0] bridge_dout,
    output logic        bridge_ok,
    output logic        bus_err,
    output logic        sub_br,
    output logic [18:0] sub_A,
    output logic [1:0]  sub_dsn,
    output logic        sub_rnw,
    output logic [15:0] sub_dout,
    input  logic [15:0] sub_din,
    input  logic        sub_ok
);
    typedef enum logic [2:0] {IDLE, REQ, XFER, DONE, KEEP} state_t;

    localparam logic [7:0] SET = 8'(SETTLE);
    localparam logic [7:0] HLD = 8'(HOLD);

    state_t      state, state_nx;
    logic [7:0]  settle, settle_nx, settle_inc, keep, keep_nx;
    logic [15:0] bd_nx;
    logic [1:0]  dsn_l;
    logic        latch;

    // Bus request, strobes and completion follow directly from the state
    assign sub_br    = state != IDLE;
    assign bridge_ok = state == DONE;
    assign sub_dsn   = (state == XFER || state == DONE) ? dsn_l : 2'b11;

`ifdef JTOUTRUN_BRIDGE_TIMEOUT_EN
    localparam logic [7:0] TO = 8'(TIMEOUT);
    logic [7:0] wait_cnt, wait_nx;
    logic       err_nx, timed_out;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign bus_err = 1'b0;
`endif

    // Next-state, counters and read-data capture
    always_comb begin
        state_nx   = state;
        settle_nx  = settle;
        keep_nx    = keep;
        bd_nx      = bridge_dout;
        latch      = 1'b0;
        settle_inc = (settle == SET) ? settle : settle + 8'd1;
        case (state)
            IDLE: if (main_cs) begin
                latch    = 1'b1;
                state_nx = REQ;
            end
            REQ: if (sub_ok) begin
                settle_nx = 8'd0;
                state_nx  = XFER;
            end
            XFER: begin
                settle_nx = settle_inc;
                if (settle_inc == SET && sub_ok) begin
                    if (sub_rnw) bd_nx = sub_din;
                    state_nx = DONE;
                end
            end
            DONE: if (!main_cs) begin
                keep_nx  = HLD;
                state_nx = KEEP;
            end
            KEEP: begin
                if (main_cs) begin
                    latch     = 1'b1;
                    settle_nx = 8'd0;
                    state_nx  = XFER;
                end else if (keep == 8'd0) state_nx = IDLE;
                else keep_nx = keep - 8'd1;
            end
            default: state_nx = IDLE;
        endcase
`ifdef JTOUTRUN_BRIDGE_TIMEOUT_EN
        wait_nx   = latch ? 8'd0 : wait_cnt;
        err_nx    = bus_err;
        timed_out = 1'b0;
        if (state == REQ || state == XFER) begin
            wait_nx   = wait_cnt + 8'd1;
            timed_out = state_nx == state && wait_nx == TO;
        end
        if (timed_out) begin
            bd_nx    = 16'hFFFF;
            err_nx   = 1'b1;
            state_nx = DONE;
        end
`endif
    end

    // State and latched transaction registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            settle      <= 8'd0;
            keep        <= 8'd0;
            bridge_dout <= 16'd0;
            sub_A       <= 19'd0;
            dsn_l       <= 2'b11;
            sub_rnw     <= 1'b0;
            sub_dout    <= 16'd0;
        end else begin
            state       <= state_nx;
            settle      <= settle_nx;
            keep        <= keep_nx;
            bridge_dout <= bd_nx;
            if (latch) begin
                sub_A    <= main_A;
                dsn_l    <= main_dsn;
                sub_rnw  <= main_rnw;
                sub_dout <= main_dout;
            end
        end
    end

`ifdef JTOUTRUN_BRIDGE_TIMEOUT_EN
    // Wait counter and sticky error flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= 8'd0;
            bus_err  <= 1'b0;
        end else begin
            wait_cnt <= wait_nx;
            bus_err  <= err_nx;
        end
    end
`endif
endmodule
